// File: rtl/sd_pkg.sv
// Shared constants, command frame layout and state encoding for the SD SPI sector reader.
package sd_pkg;

   localparam logic [7:0]  CMD17_HEAD  = 8'h51;
   localparam logic [7:0]  CMD_CRC     = 8'hFF;
   localparam logic [7:0]  START_TOKEN = 8'hFE;
   localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
   localparam logic [7:0]  R1_READY    = 8'h00;
   localparam int unsigned BLOCK_BYTES = 512;
   localparam int unsigned BYTE_IDX_W  = 9;
   localparam int unsigned CMD_BITS    = 48;

   typedef struct packed {
      logic [7:0]  head;
      logic [31:0] arg;
      logic [7:0]  crc;
   } sd_cmd_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND_CMD,
      ST_WAIT_R1,
      ST_READ_R1,
      ST_WAIT_TOKEN,
      ST_READ_DATA,
      ST_READ_CRC,
      ST_TAIL,
      ST_FAIL
   } sd_state_e;

   function automatic sd_cmd_t cmd17_frame(input logic [31:0] addr);
      sd_cmd_t f;
      f.head = CMD17_HEAD;
      f.arg  = addr;
      f.crc  = CMD_CRC;
      return f;
   endfunction

endpackage

// File: rtl/sd_spi_rx_byte.sv
// MSB-first DO deserialiser; done_c marks the sample that completes a byte.
module sd_spi_rx_byte (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       en,
   input  logic       realign,
   input  logic       din,
   output logic [7:0] byte_c,
   output logic       done_c
);

   logic [6:0] sh;
   logic [2:0] bit_cnt;

   // realign discards the current sample so the next one becomes bit 7
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sh      <= '0;
         bit_cnt <= '0;
      end else if (realign) begin
         bit_cnt <= '0;
      end else if (en) begin
         sh      <= {sh[5:0], din};
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign byte_c = {sh, din};
   assign done_c = en && !realign && (bit_cnt == 3'd7);

endmodule

// File: rtl/sd_read_sector.sv
// CMD17 single-block read over SPI: sends the command, checks R1 and the start token,
// then streams the 512 data bytes out with an index.
module sd_read_sector
   import sd_pkg::*;
#(
   parameter int unsigned R1_TIMEOUT    = 64,
   parameter int unsigned TOKEN_TIMEOUT = 4096,
   parameter int unsigned TAIL_CLKS     = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  INIT_OK,
   input  logic                  START,
   input  logic [31:0]           ADDR,
   input  logic                  DO,
   output logic                  DI,
   output logic                  CS,
   output logic [7:0]            DATA,
   output logic                  DATA_VALID,
   output logic [BYTE_IDX_W-1:0] BYTE_IDX,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR
);

   // one shared counter serves the command, R1, token, CRC and tail phases
   localparam int unsigned CNT_W = $clog2(TOKEN_TIMEOUT + R1_TIMEOUT + TAIL_CLKS + CMD_BITS);

   sd_state_e             state, state_nx;
   logic [31:0]           addr_q;
   logic [CMD_BITS-1:0]   cmd_sh;
   logic [CNT_W-1:0]      cnt, cnt_d;
   logic [BYTE_IDX_W-1:0] byte_cnt;
   logic                  cs_d, busy_d, done_d, error_d, dv_d, accept_c;
   logic                  rx_active_c, rx_realign_c, rx_done_c;
   logic [7:0]            rx_byte_c;

   assign rx_active_c  = state inside {ST_WAIT_R1, ST_READ_R1, ST_WAIT_TOKEN,
                                       ST_READ_DATA, ST_READ_CRC};
   assign rx_realign_c = !rx_active_c || (state == ST_WAIT_R1 && DO);

   sd_spi_rx_byte u_rx (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .en      (rx_active_c),
      .realign (rx_realign_c),
      .din     (DO),
      .byte_c  (rx_byte_c),
      .done_c  (rx_done_c)
   );

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (START && INIT_OK) state_nx = ST_LOAD;
         ST_LOAD:     state_nx = ST_SEND_CMD;
         ST_SEND_CMD: if (cnt == CNT_W'(CMD_BITS - 1)) state_nx = ST_WAIT_R1;
         ST_WAIT_R1: begin
            if (!DO)                                  state_nx = ST_READ_R1;
            else if (cnt == CNT_W'(R1_TIMEOUT - 1))   state_nx = ST_FAIL;
         end
         ST_READ_R1:
            if (rx_done_c) state_nx = (rx_byte_c == R1_READY) ? ST_WAIT_TOKEN : ST_FAIL;
         ST_WAIT_TOKEN: begin
            if (rx_done_c) begin
               if (rx_byte_c == START_TOKEN)                 state_nx = ST_READ_DATA;
               else if (rx_byte_c != IDLE_BYTE)              state_nx = ST_FAIL;
               else if (cnt == CNT_W'(TOKEN_TIMEOUT - 1))    state_nx = ST_FAIL;
            end
         end
         ST_READ_DATA:
            if (rx_done_c && byte_cnt == BYTE_IDX_W'(BLOCK_BYTES - 1)) state_nx = ST_READ_CRC;
         ST_READ_CRC: if (rx_done_c && cnt == CNT_W'(1)) state_nx = ST_TAIL;
         ST_TAIL:     if (cnt == CNT_W'(TAIL_CLKS - 1)) state_nx = ST_IDLE;
         ST_FAIL:     if (cnt == CNT_W'(TAIL_CLKS - 1)) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   // output and counter decode, registered below
   always_comb begin
      accept_c = (state == ST_IDLE) && (state_nx == ST_LOAD);
      cs_d     = !(state_nx inside {ST_SEND_CMD, ST_WAIT_R1, ST_READ_R1, ST_WAIT_TOKEN,
                                    ST_READ_DATA, ST_READ_CRC});
      busy_d   = (state_nx != ST_IDLE);
      done_d   = (state == ST_TAIL) && (state_nx == ST_IDLE);
      dv_d     = (state == ST_READ_DATA) && rx_done_c;
      error_d  = ERROR;
      cnt_d    = cnt;
      if (accept_c)                                error_d = 1'b0;
      if (state_nx == ST_FAIL && state != ST_FAIL) error_d = 1'b1;
      if (state_nx != state) begin
         cnt_d = '0;
      end else begin
         case (state)
            ST_SEND_CMD, ST_WAIT_R1, ST_TAIL, ST_FAIL: cnt_d = cnt + 1'b1;
            ST_WAIT_TOKEN, ST_READ_CRC:                if (rx_done_c) cnt_d = cnt + 1'b1;
            default:                                   cnt_d = cnt;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         CS         <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERROR      <= 1'b0;
         DATA_VALID <= 1'b0;
         DATA       <= '0;
         BYTE_IDX   <= '0;
         byte_cnt   <= '0;
         cnt        <= '0;
         addr_q     <= '0;
         cmd_sh     <= '0;
      end else begin
         CS         <= cs_d;
         BUSY       <= busy_d;
         DONE       <= done_d;
         ERROR      <= error_d;
         DATA_VALID <= dv_d;
         cnt        <= cnt_d;
         if (accept_c) begin
            addr_q   <= ADDR;
            byte_cnt <= '0;
         end
         if (state == ST_LOAD)          cmd_sh <= cmd17_frame(addr_q);
         else if (state == ST_SEND_CMD) cmd_sh <= {cmd_sh[CMD_BITS-2:0], 1'b1};
         if (dv_d) begin
            DATA     <= rx_byte_c;
            BYTE_IDX <= byte_cnt;
            byte_cnt <= byte_cnt + 1'b1;
         end
      end
   end

   // DI changes on the falling edge so the card sees a stable bit at the rising edge
   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) DI <= 1'b1;
      else        DI <= (state == ST_SEND_CMD) ? cmd_sh[CMD_BITS-1] : 1'b1;
   end

endmodule

// File: tb/tb_sd_read_sector.sv
// Directed bench for sd_read_sector with a scripted SPI card model.
module tb_sd_read_sector;

   logic       CLK, RST_N, INIT_OK, START, DO;
   logic [31:0] ADDR;
   logic       DI, CS, DATA_VALID, BUSY, DONE, ERROR;
   logic [7:0] DATA;
   logic [8:0] BYTE_IDX;

   sd_read_sector dut (
      .CLK(CLK), .RST_N(RST_N), .INIT_OK(INIT_OK), .START(START), .ADDR(ADDR),
      .DO(DO), .DI(DI), .CS(CS), .DATA(DATA), .DATA_VALID(DATA_VALID),
      .BYTE_IDX(BYTE_IDX), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      int          gap;
      logic [7:0]  r1;
      int          ff;
      logic [7:0]  token;
      logic [7:0]  xorv;
      bit          exp_err;
      int          exp_dv;
      int          exp_done;
   } vec_t;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   bit resp_bits[$];
   logic [7:0] cur_xor = 8'h00;

   // card state
   logic [47:0] cmd_cap;
   int cmd_cnt = 0, rd_ptr = 0, last_pop_cyc = -1;
   bit resp_go = 0;

   // monitor state
   int tot_dv = 0, tot_bad = 0, tot_done = 0, mon_idx = 0, err_rise_cyc = -1;
   logic err_prev = 1'b0;

   always @(posedge CLK) cyc++;

   // card: captures the command on DI, then plays resp_bits on DO from the falling edge
   always @(CLK) begin
      if (CLK) begin
         if (CS !== 1'b0) begin
            cmd_cnt = 0; resp_go = 0; rd_ptr = 0;
         end else if (cmd_cnt < 48) begin
            cmd_cap = {cmd_cap[46:0], DI};
            cmd_cnt++;
            if (cmd_cnt == 48) resp_go = 1;
         end
      end else begin
         if (resp_go && rd_ptr < resp_bits.size()) begin
            DO = resp_bits[rd_ptr];
            if (rd_ptr == resp_bits.size() - 1) last_pop_cyc = cyc;
            rd_ptr++;
         end else begin
            DO = 1'b1;
         end
      end
   end

   always @(negedge CLK) begin
      if (!BUSY) mon_idx = 0;
      if (DATA_VALID) begin
         if (BYTE_IDX !== 9'(mon_idx) || DATA !== (8'(mon_idx) ^ cur_xor)) tot_bad++;
         tot_dv++;
         mon_idx++;
      end
      if (DONE) tot_done++;
      if (ERROR && !err_prev) err_rise_cyc = cyc;
      err_prev = ERROR;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) resp_bits.push_back(b[i]);
   endtask

   task automatic load_card(input vec_t v);
      resp_bits.delete();
      for (int i = 0; i < v.gap; i++) resp_bits.push_back(1'b1);
      push_byte(v.r1);
      for (int i = 0; i < v.ff; i++) push_byte(8'hFF);
      push_byte(v.token);
      if (v.token == 8'hFE) begin
         for (int i = 0; i < 512; i++) push_byte(8'(i) ^ v.xorv);
         push_byte(8'h3C);
         push_byte(8'hC3);
      end
      cur_xor = v.xorv;
   endtask

   task automatic start_read(input logic [31:0] a);
      @(negedge CLK);
      ADDR = a; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("busy_on_accept", 64'(BUSY), 64'd1);
      chk("error_cleared_on_accept", 64'(ERROR), 64'd0);
      chk("cs_high_at_accept", 64'(CS), 64'd1);
      @(negedge CLK);
      chk("cs_low_after_load", 64'(CS), 64'd0);
      #1;
      chk("di_first_cmd_bit", 64'(DI), 64'd0);
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (!BUSY) begin ok = 1; break; end
      end
      chk("busy_release_in_budget", 64'(ok), 64'd1);
      repeat (2) @(negedge CLK);
   endtask

   task automatic finish_check(input vec_t v, input int k, input int b_dv, input int b_bad,
                               input int b_done);
      logic [47:0] e;
      e = {8'h51, v.addr, 8'hFF};
      wait_idle(40000);
      chk($sformatf("v%0d_cmd_frame", k), 64'(cmd_cap), 64'(e));
      chk($sformatf("v%0d_error", k), 64'(ERROR), 64'(v.exp_err));
      chk($sformatf("v%0d_dv_count", k), 64'(tot_dv - b_dv), 64'(v.exp_dv));
      chk($sformatf("v%0d_data_bad", k), 64'(tot_bad - b_bad), 64'd0);
      chk($sformatf("v%0d_done_count", k), 64'(tot_done - b_done), 64'(v.exp_done));
      chk($sformatf("v%0d_cs_idle", k), 64'(CS), 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int b_dv, b_bad, b_done;
      load_card(v);
      b_dv = tot_dv; b_bad = tot_bad; b_done = tot_done;
      start_read(v.addr);
      finish_check(v, k, b_dv, b_bad, b_done);
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      vec_t vr;
      int b_dv, b_bad, b_done;
      bit hit;

      // addr, gap bits, R1, FF bytes, token, data xor, exp error, exp DV, exp DONE
      vecs[0] = '{32'h0000_1234, 24, 8'h00, 2, 8'hFE, 8'h00, 1'b0, 512, 1};
      vecs[1] = '{32'h0000_0001,  8, 8'h04, 0, 8'hFE, 8'h00, 1'b1,   0, 0};
      vecs[2] = '{32'hCAFE_0000,  0, 8'h00, 1, 8'h09, 8'h00, 1'b1,   0, 0};
      vecs[3] = '{32'hDEAD_BEEF,  0, 8'h00, 0, 8'hFE, 8'hA5, 1'b0, 512, 1};
      vecs[4] = '{32'h0000_0000, 63, 8'h00, 5, 8'hFE, 8'h3C, 1'b0, 512, 1};
      vecs[5] = '{32'h0000_0007, 64, 8'h00, 0, 8'hFE, 8'h00, 1'b1,   0, 0};

      RST_N = 1'b0; INIT_OK = 1'b0; START = 1'b0; ADDR = '0;
      #12;
      chk("rst_cs", 64'(CS), 64'd1);
      chk("rst_di", 64'(DI), 64'd1);
      chk("rst_data", 64'(DATA), 64'd0);
      chk("rst_dv", 64'(DATA_VALID), 64'd0);
      chk("rst_byte_idx", 64'(BYTE_IDX), 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_done", 64'(DONE), 64'd0);
      chk("rst_error", 64'(ERROR), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // START with INIT_OK low must be ignored
      ADDR = 32'h1111_1111; START = 1'b1;
      repeat (6) @(negedge CLK);
      chk("gated_busy", 64'(BUSY), 64'd0);
      chk("gated_cs", 64'(CS), 64'd1);
      START = 1'b0; INIT_OK = 1'b1;

      for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

      // token timeout: ERROR must rise right after the 4096th FF byte
      resp_bits.delete();
      for (int i = 0; i < 16; i++) resp_bits.push_back(1'b1);
      push_byte(8'h00);
      for (int i = 0; i < 4096; i++) push_byte(8'hFF);
      b_dv = tot_dv; b_done = tot_done;
      start_read(32'h0000_4096);
      wait_idle(40000);
      chk("tok_timeout_error", 64'(ERROR), 64'd1);
      chk("tok_timeout_exact_byte", 64'(err_rise_cyc), 64'(last_pop_cyc + 1));
      chk("tok_timeout_no_done", 64'(tot_done - b_done), 64'd0);
      chk("tok_timeout_no_dv", 64'(tot_dv - b_dv), 64'd0);

      // START while busy and INIT_OK dropping mid-transfer are both ignored
      vr = '{32'h0BAD_F00D, 24, 8'h00, 3, 8'hFE, 8'h5A, 1'b0, 512, 1};
      load_card(vr);
      b_dv = tot_dv; b_bad = tot_bad; b_done = tot_done;
      start_read(vr.addr);
      repeat (100) @(negedge CLK);
      ADDR = 32'h7777_7777; START = 1'b1; INIT_OK = 1'b0;
      repeat (3) @(negedge CLK);
      START = 1'b0;
      finish_check(vr, 6, b_dv, b_bad, b_done);
      INIT_OK = 1'b1;

      // asynchronous reset in the middle of data byte 200
      vr = '{32'h0000_0200, 24, 8'h00, 2, 8'hFE, 8'h11, 1'b0, 512, 1};
      load_card(vr);
      b_dv = tot_dv;
      start_read(vr.addr);
      hit = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge CLK);
         if (tot_dv - b_dv >= 200) begin hit = 1; break; end
      end
      chk("reached_byte_200", 64'(hit), 64'd1);
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      chk("midrst_cs", 64'(CS), 64'd1);
      chk("midrst_di", 64'(DI), 64'd1);
      chk("midrst_busy", 64'(BUSY), 64'd0);
      chk("midrst_dv", 64'(DATA_VALID), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      vr.addr = 32'h0000_0201;
      run_vec(vr, 7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sd_read_sector.md
# sd_read_sector

Single-block SD-card reader in SPI mode that runs after card initialisation completes. On request it issues CMD17 for a 32-bit block address, waits for the R1 response and the start token, and streams the 512 data bytes out one byte at a time. It shares the SD bus with the initialisation block: the top level selects this block's CS/DI once the initialisation OK is high. CLK is also the SD SCLK.

## Interface
- R1_TIMEOUT, 64: max bit-times waited for R1 start bit (DO low) after the command.
- TOKEN_TIMEOUT, 4096: max bytes waited for the 0xFE start token.
- TAIL_CLKS, 8: dummy clocks sent with CS high after the transfer.
- CLK  in  1  system clock = SD SCLK.
- RST_N  in  1  asynchronous, active-low reset.
- INIT_OK  in  1  high once initialisation finished; START ignored while low.
- START  in  1  read request, sampled on rising edge in IDLE.
- ADDR  in  32  block address (SDHC, 512-byte units), latched on accepted START.
- DO  in  1  card MISO.
- DI  out  1  card MOSI.
- CS  out  1  card chip select, active low.
- DATA  out  8  received byte, MSB first on the wire.
- DATA_VALID  out  1  one-cycle pulse, DATA valid.
- BYTE_IDX  out  9  index 0..511 of the byte on DATA.
- BUSY  out  1  high from accepted START until DONE/ERROR.
- DONE  out  1  one-cycle pulse, sector read successfully.
- ERROR  out  1  sticky failure flag, cleared by the next accepted START.

## Operation
- States: IDLE, LOAD, SEND_CMD, WAIT_R1, READ_R1, WAIT_TOKEN, READ_DATA, READ_CRC, TAIL, FAIL.
- IDLE: CS=1, DI=1. START=1 and INIT_OK=1 -> LOAD; ADDR latched; ERROR cleared; BUSY set.
- LOAD: 48-bit frame {8'h51, ADDR, 8'hFF} loaded into the shift register; CS driven low -> SEND_CMD.
- SEND_CMD: 48 bits shifted MSB first on DI -> WAIT_R1. DI=1 in every other state.
- WAIT_R1: first DO=0 sample starts READ_R1; R1_TIMEOUT bit-times without it -> FAIL.
- READ_R1: 8 bits including the start bit. R1==8'h00 -> WAIT_TOKEN; any other value -> FAIL.
- WAIT_TOKEN: bytes shifted in with byte alignment from the R1 end. 8'hFE -> READ_DATA. 8'hFF -> keep waiting. Any other byte (data error token) -> FAIL. TOKEN_TIMEOUT bytes -> FAIL.
- READ_DATA: 512 bytes. Each completed byte drives DATA and BYTE_IDX with a DATA_VALID pulse. The 9-bit byte counter wraps 511->0 on exit -> READ_CRC.
- READ_CRC: 16 bits clocked and discarded; no CRC check -> TAIL.
- TAIL: CS=1, DI=1 for TAIL_CLKS clocks. Then DONE pulse, BUSY=0 -> IDLE.
- FAIL: CS=1; ERROR set; TAIL_CLKS clocks sent; BUSY=0 -> IDLE. DONE is not pulsed.
- START while BUSY: ignored.
- INIT_OK falling mid-transfer: ignored. The transfer completes or fails normally.

## Timing
- Reset values (asynchronous, RST_N low): state IDLE, CS=1, DI=1, DATA=0, DATA_VALID=0, BYTE_IDX=0, BUSY=0, DONE=0, ERROR=0, all counters 0.
- Reset mid-transfer: all of the above applied immediately. No tail clocks are sent.
- DI is updated on the falling edge of CLK. The card samples it on the rising edge.
- DO is sampled on the rising edge of CLK. All state, counters and flags are updated on the rising edge.
- START accepted at edge N -> CS=0 from edge N+1. The first command bit appears on DI at the falling edge after N+1.
- The last command bit is on DI for exactly one CLK period. The R1 search begins at the next rising edge.
- DATA_VALID is asserted in the cycle after the 8th bit of a byte is sampled. Minimum spacing is 8 cycles.
- DONE is asserted in the cycle after the last tail clock.
- Minimum total latency for R1 at first bit and token as the first byte: 2 + 48 + 8 + 8 + 4096 + 16 + TAIL_CLKS cycles.

## Structure
- Shared package sd_pkg holds:
  - CMD17 head 8'h51 and dummy CRC 8'hFF;
  - start token 8'hFE;
  - R1 ready value 8'h00;
  - block size 512;
  - the state encoding.
- Sub-module sd_spi_rx_byte: 8-bit MSB-first DO deserialiser with a byte-done strobe and a realign input. It is used by WAIT_R1, READ_R1, WAIT_TOKEN, READ_DATA and READ_CRC.
- The command shift register is inline.

## Test plan
- Nominal read, ADDR=32'h0000_1234: DI carries 51 00 00 12 34 FF. Card model gives R1=00 after 3 idle bytes, then FE and bytes 0..511 = i[7:0]. Required: 512 DATA_VALID pulses with DATA=BYTE_IDX[7:0], one DONE pulse, ERROR=0.
- R1 error: card returns R1=8'h04. Required: FAIL, ERROR=1, no DATA_VALID, CS=1 after 8 tail clocks, BUSY=0.
- Token timeout: card returns R1=00, then only FF. Required: ERROR after exactly 4096 bytes.
- Data error token: card returns 8'h09 instead of FE. Required: ERROR, DONE=0.
- Protocol gating: START while INIT_OK=0 is ignored. START while BUSY does not restart the transfer. A second read after ERROR clears ERROR on acceptance.
- Reset: RST_N low in the middle of READ_DATA byte 200. Required: CS=1, DI=1, BUSY=0 immediately. The next START performs a full, correct read.
